// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types plus the GPIO register map, FSM state enums and decode helpers.
package axi4l_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam addr_t GPIO_OUT      = 32'h00;
  localparam addr_t GPIO_SET      = 32'h04;
  localparam addr_t GPIO_CLR      = 32'h08;
  localparam addr_t GPIO_TGL      = 32'h0C;
  localparam addr_t GPIO_IN       = 32'h10;
  localparam addr_t GPIO_IRQ_EN   = 32'h14;
  localparam addr_t GPIO_IRQ_STAT = 32'h18;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP} r_state_t;

  typedef enum logic [2:0] {
    SEL_OUT, SEL_SET, SEL_CLR, SEL_TGL, SEL_IN, SEL_IRQ_EN, SEL_IRQ_STAT, SEL_NONE
  } reg_sel_t;

  // Registers are decoded on the word index addr[11:2] only.
  function automatic reg_sel_t reg_sel(input logic [9:0] idx);
    reg_sel_t s;
    case (idx)
      GPIO_OUT[11:2]:      s = SEL_OUT;
      GPIO_SET[11:2]:      s = SEL_SET;
      GPIO_CLR[11:2]:      s = SEL_CLR;
      GPIO_TGL[11:2]:      s = SEL_TGL;
      GPIO_IN[11:2]:       s = SEL_IN;
      GPIO_IRQ_EN[11:2]:   s = SEL_IRQ_EN;
      GPIO_IRQ_STAT[11:2]: s = SEL_IRQ_STAT;
      default:             s = SEL_NONE;
    endcase
    return s;
  endfunction

  function automatic data_t strb_mask(input strb_t strb);
    data_t m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle with a single clock and synchronous active-low reset.
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  import axi4l_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport master (
    input  aclk, aresetn,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

endinterface

// File: rtl/gpio_in_cond.sv
// One GPIO input bit: synchroniser, optional debouncer (AXI4L_GPIO_DEBOUNCE_EN), rising-edge detect.
module gpio_in_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl;
  logic                   prev_q, prev_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], din};

`ifdef AXI4L_GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  // Any cycle where the synchronised bit agrees with the debounced one restarts the window.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q[SYNC_STAGES-1] != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = sync_q[SYNC_STAGES-1];
      else                                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign lvl = db_q;
`else
  localparam int UNUSED_DB_CYCLES = DEBOUNCE_CYCLES;
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  always_comb prev_d = lvl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl_o  = lvl;
  assign rise_o = lvl & ~prev_q;

endmodule

// File: rtl/axi4l_gpio.sv
// AXI4-Lite GPIO: OUT/SET/CLR/TGL outputs, synchronised inputs, rising-edge IRQ.
// Define AXI4L_GPIO_DEBOUNCE_EN to debounce inputs over DEBOUNCE_CYCLES cycles.
module axi4l_gpio
  import axi4l_pkg::*;
#(
  parameter int N_OUT           = 4,
  parameter int N_IN            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  axi4l_if.slave           axi,
  output logic [N_OUT-1:0] gpio_o,
  input  logic [N_IN-1:0]  gpio_i,
  output logic             irq
);

  logic clk, rst_n;
  assign clk   = axi.aclk;
  assign rst_n = axi.aresetn;

  // ---------------------------------------------------------------- inputs
  logic [N_IN-1:0] in_lvl, in_rise;

  gpio_in_cond #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_in [N_IN-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (gpio_i),
    .lvl_o  (in_lvl),
    .rise_o (in_rise)
  );

  // ---------------------------------------------------------------- write FSM
  w_state_t w_state_q;
  logic     awready_q, wready_q, bvalid_q;
  resp_t    bresp_q;
  addr_t    awaddr_q;
  data_t    wdata_q;
  strb_t    wstrb_q;

  logic     aw_hs, w_hs, wr_en;
  addr_t    wr_addr;
  data_t    wr_data;
  strb_t    wr_strb;
  reg_sel_t wr_sel;
  resp_t    wr_resp;

  assign aw_hs = axi.awvalid & awready_q;
  assign w_hs  = axi.wvalid  & wready_q;

  // Commit source: live bus values, or whichever half was parked earlier.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = axi.awaddr;
    wr_data = axi.wdata;
    wr_strb = axi.wstrb;
    case (w_state_q)
      W_IDLE:   wr_en = aw_hs & w_hs;
      W_HAVE_A: begin
        wr_en   = w_hs;
        wr_addr = awaddr_q;
      end
      W_HAVE_D: begin
        wr_en   = aw_hs;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
      end
      default: ;
    endcase
    wr_sel  = reg_sel(wr_addr[11:2]);
    wr_resp = (wr_sel == SEL_NONE) ? SLVERR : OKAY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_state_q <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp;
          end else if (aw_hs) begin
            w_state_q <= W_HAVE_A;
            awready_q <= 1'b0;
            awaddr_q  <= axi.awaddr;
          end else if (w_hs) begin
            w_state_q <= W_HAVE_D;
            wready_q  <= 1'b0;
            wdata_q   <= axi.wdata;
            wstrb_q   <= axi.wstrb;
          end
        end
        W_HAVE_A: begin
          if (w_hs) begin
            w_state_q <= W_RESP;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp;
          end
        end
        W_HAVE_D: begin
          if (aw_hs) begin
            w_state_q <= W_RESP;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp;
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- registers
  logic [N_OUT-1:0] out_q, out_d;
  logic [N_IN-1:0]  irq_en_q, irq_en_d;
  logic [N_IN-1:0]  irq_stat_q, irq_stat_d;
  logic [N_IN-1:0]  stat_clr;
  logic             irq_q, irq_d;
  data_t            wmask, wbits;

  always_comb begin
    out_d    = out_q;
    irq_en_d = irq_en_q;
    stat_clr = '0;
    wmask    = strb_mask(wr_strb);
    wbits    = wr_data & wmask;
    if (wr_en) begin
      case (wr_sel)
        SEL_OUT:      out_d    = (out_q & ~wmask[N_OUT-1:0]) | wbits[N_OUT-1:0];
        SEL_SET:      out_d    = out_q | wbits[N_OUT-1:0];
        SEL_CLR:      out_d    = out_q & ~wbits[N_OUT-1:0];
        SEL_TGL:      out_d    = out_q ^ wbits[N_OUT-1:0];
        SEL_IRQ_EN:   irq_en_d = (irq_en_q & ~wmask[N_IN-1:0]) | wbits[N_IN-1:0];
        SEL_IRQ_STAT: stat_clr = wbits[N_IN-1:0];
        default: ;
      endcase
    end
    // A fresh edge beats a coincident W1C on the same bit.
    irq_stat_d = (irq_stat_q & ~stat_clr) | in_rise;
    irq_d      = |(irq_stat_q & irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      irq_q      <= irq_d;
    end
  end

  // ---------------------------------------------------------------- read FSM
  r_state_t r_state_q;
  logic     arready_q, rvalid_q, ar_hs;
  data_t    rdata_q, rd_data;
  resp_t    rresp_q, rd_resp;
  reg_sel_t rd_sel;

  assign ar_hs = axi.arvalid & arready_q;

  always_comb begin
    rd_sel  = reg_sel(axi.araddr[11:2]);
    rd_data = '0;
    rd_resp = OKAY;
    case (rd_sel)
      SEL_OUT:      rd_data[N_OUT-1:0] = out_q;
      SEL_IN:       rd_data[N_IN-1:0]  = in_lvl;
      SEL_IRQ_EN:   rd_data[N_IN-1:0]  = irq_en_q;
      SEL_IRQ_STAT: rd_data[N_IN-1:0]  = irq_stat_q;
      SEL_NONE:     rd_resp            = SLVERR;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_state_q <= R_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data;
            rresp_q   <= rd_resp;
          end
        end
        R_RESP: begin
          if (axi.rready) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{wmask, wbits, wr_addr[31:12], wr_addr[1:0],
                       axi.araddr[31:12], axi.araddr[1:0]};

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign gpio_o      = out_q;
  assign irq         = irq_q;

endmodule
